// File: rtl/cordic_rotator_seq_if.sv
// Angle-in / cos-sin-out handshake bundle for the sequential CORDIC rotator.
// The master side drives angles and consumes results; the slave side is the engine.
interface cordic_rotator_seq_if #(
  parameter int WIDTH = 23
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] angle_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] cos_out;
  logic signed [WIDTH-1:0] sin_out;

  modport master (
    output in_valid,
    output angle_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  cos_out,
    input  sin_out
  );

  modport slave (
    input  in_valid,
    input  angle_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output cos_out,
    output sin_out
  );
endinterface

// File: rtl/cordic_rotator_seq.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, NITER per angle.
// Returns cos/sin of the accepted angle in the same signed fixed-point format.
module cordic_iter_stage #(
  parameter int WIDTH = 23,
  parameter int CW    = 5
) (
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] y_i,
  input  logic signed [WIDTH-1:0] z_i,
  input  logic signed [WIDTH-1:0] atan_i,
  input  logic        [CW-1:0]    i,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [WIDTH-1:0] y_o,
  output logic signed [WIDTH-1:0] z_o
);
  logic signed [WIDTH-1:0] xs;
  logic signed [WIDTH-1:0] ys;
  logic                    neg;

  always_comb begin
    xs  = x_i >>> i;
    ys  = y_i >>> i;
    neg = z_i[WIDTH-1];
    x_o = neg ? x_i + ys : x_i - ys;
    y_o = neg ? y_i - xs : y_i + xs;
    z_o = neg ? z_i + atan_i : z_i - atan_i;
  end
endmodule

module cordic_rotator_seq #(
  parameter int FRACS = 21,
  parameter int INTS  = 1,
  parameter int WIDTH = INTS + FRACS + 1,
  parameter int NITER = 16
) (
  input logic               clk,
  input logic               rst,
  cordic_rotator_seq_if.slave io
);
  localparam int CW = $clog2(FRACS + 1);
  localparam logic [CW-1:0] LAST = CW'(NITER - 1);
  localparam logic signed [WIDTH-1:0] KVAL =
    WIDTH'($rtoi(0.6072529350 * (2.0 ** FRACS) + 0.5));

  // atan(2^-k) by odd power series; k=0 uses pi/4 where the series converges slowly
  function automatic logic [WIDTH-2:0] atan_fx(input int k);
    real x;
    real p;
    real s;
    s = 0.0;
    if (k == 0) begin
      s = 0.78539816339744831;
    end else begin
      x = 1.0 / (2.0 ** k);
      p = x;
      for (int n = 0; n < 40; n++) begin
        s = (n % 2 == 1) ? s - p / (2 * n + 1) : s + p / (2 * n + 1);
        p = p * x * x;
      end
    end
    return (WIDTH-1)'($rtoi(s * (2.0 ** FRACS) + 0.5));
  endfunction

  logic signed [WIDTH-1:0] atan_tab [2**CW];

  for (genvar k = 0; k < 2**CW; k++) begin : g_atan
    if (k < NITER) begin : g_v
      localparam logic [WIDTH-2:0] A = atan_fx(k);
      assign atan_tab[k] = {1'b0, A};
    end else begin : g_z
      assign atan_tab[k] = '0;
    end
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic signed [WIDTH-1:0] z_q, z_d;
  logic        [CW-1:0]    cnt_q, cnt_d;
  logic signed [WIDTH-1:0] cos_q, cos_d;
  logic signed [WIDTH-1:0] sin_q, sin_d;
  logic signed [WIDTH-1:0] x_n, y_n, z_n;
  logic                    in_ready;

  cordic_iter_stage #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_stage (
    .x_i   (x_q),
    .y_i   (y_q),
    .z_i   (z_q),
    .atan_i(atan_tab[cnt_q]),
    .i     (cnt_q),
    .x_o   (x_n),
    .y_o   (y_n),
    .z_o   (z_n)
  );

  assign in_ready     = (state_q == S_IDLE) && !rst;
  assign io.in_ready  = in_ready;
  assign io.out_valid = (state_q == S_DONE);
  assign io.cos_out   = cos_q;
  assign io.sin_out   = sin_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    unique case (state_q)
      S_IDLE: begin
        if (io.in_valid && in_ready) begin
          state_d = S_RUN;
          x_d     = KVAL;
          y_d     = '0;
          z_d     = io.angle_in;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        x_d   = x_n;
        y_d   = y_n;
        z_d   = z_n;
        cnt_d = cnt_q + 1'b1;
        // result registers hold the last answer after it is consumed
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cos_d   = x_n;
          sin_d   = y_n;
        end
      end
      S_DONE: begin
        if (io.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end
endmodule

// File: tb/tb_cordic_rotator_seq.sv
// Bench for cordic_rotator_seq: directed spec cases, handshake holds, reset abort
// and random angles against a floating-point cos/sin reference.
module tb_cordic_rotator_seq;
  localparam int W = 23;
  localparam int N = 16;
  localparam int P4 = 1647099;
  localparam int M6 = -1098066;
  localparam int AMAX = 3294199;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cordic_rotator_seq_if #(.WIDTH(W)) io ();

  cordic_rotator_seq #(
    .FRACS(21),
    .INTS (1),
    .WIDTH(W),
    .NITER(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ov_cnt = 0;
  int acc_cyc[$];
  int res_cyc[$];
  int res_c[$];
  int res_s[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (io.out_valid) ov_cnt <= ov_cnt + 1;
    if (!rst && io.in_valid && io.in_ready) acc_cyc.push_back(cyc);
    if (io.out_valid && io.out_ready) begin
      res_cyc.push_back(cyc);
      res_c.push_back(int'(io.cos_out));
      res_s.push_back(int'(io.sin_out));
    end
  end

  function automatic int rnd(input real r);
    return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
  endfunction

  function automatic int ref_cos(input int a);
    return rnd($cos(real'(a) / 2097152.0) * 2097152.0);
  endfunction

  function automatic int ref_sin(input int a);
    return rnd($sin(real'(a) / 2097152.0) * 2097152.0);
  endfunction

  task automatic chk_eq(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = (obs > exp) ? obs - exp : exp - obs;
    total++;
    assert ((d <= tol) === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic send(input int a);
    @(negedge clk);
    for (int k = 0; k < 100 && !io.in_ready; k++) @(negedge clk);
    io.in_valid = 1'b1;
    io.angle_in = W'(a);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int n);
    for (int k = 0; k < 200 && res_c.size() < n; k++) begin
      @(posedge clk);
      #1;
    end
    chk_eq(tag, int'(res_c.size() >= n), 1);
  endtask

  task automatic check_res(input string tag, input int idx, input int ec,
                           input int es, input int tol);
    if (idx < res_c.size() && idx < acc_cyc.size()) begin
      chk_tol({tag, "_cos"}, res_c[idx], ec, tol);
      chk_tol({tag, "_sin"}, res_s[idx], es, tol);
      chk_eq({tag, "_lat"}, res_cyc[idx] - acc_cyc[idx], N + 1);
    end else begin
      chk_eq({tag, "_missing"}, res_c.size(), idx + 1);
    end
  endtask

  initial begin
    int c0, s0, nacc, nov, a;
    rst = 1'b1;
    io.in_valid = 1'b0;
    io.angle_in = '0;
    io.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("rst_in_ready", int'(io.in_ready), 0);
    chk_eq("rst_out_valid", int'(io.out_valid), 0);
    chk_eq("rst_cos", int'(io.cos_out), 0);
    chk_eq("rst_sin", int'(io.sin_out), 0);
    rst = 1'b0;
    #1;
    chk_eq("post_rst_in_ready", int'(io.in_ready), 1);

    send(0);
    wait_res("t1_wait", 1);
    check_res("t1", 0, 2097152, 0, 64);
    repeat (5) @(negedge clk);
    chk_eq("t1_ov_once", ov_cnt, 1);

    send(P4);
    wait_res("t2_wait", 2);
    check_res("t2", 1, 1482910, 1482910, 64);

    send(M6);
    wait_res("t3_wait", 3);
    check_res("t3", 2, 1816186, -1048576, 64);

    io.out_ready = 1'b0;
    send(P4);
    for (int k = 0; k < 100 && !io.out_valid; k++) @(negedge clk);
    chk_eq("t4_ov_seen", int'(io.out_valid), 1);
    c0 = int'(io.cos_out);
    s0 = int'(io.sin_out);
    chk_tol("t4_cos", c0, 1482910, 64);
    chk_tol("t4_sin", s0, 1482910, 64);
    for (int j = 0; j < 10; j++) begin
      io.in_valid = 1'b1;
      io.angle_in = W'(12345 + j);
      @(negedge clk);
      chk_eq("t4_hold_ov", int'(io.out_valid), 1);
      chk_eq("t4_hold_cos", int'(io.cos_out), c0);
      chk_eq("t4_hold_sin", int'(io.sin_out), s0);
      chk_eq("t4_hold_rdy", int'(io.in_ready), 0);
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("t4_ov_drop", int'(io.out_valid), 0);
    chk_eq("t4_cos_kept", int'(io.cos_out), c0);
    chk_eq("t4_sin_kept", int'(io.sin_out), s0);
    chk_eq("t4_no_extra_acc", acc_cyc.size(), 4);

    @(negedge clk);
    io.in_valid = 1'b1;
    io.angle_in = W'(P4);
    for (int k = 0; k < 100 && acc_cyc.size() < 5; k++) @(negedge clk);
    io.angle_in = W'(M6);
    for (int k = 0; k < 100 && acc_cyc.size() < 6; k++) @(negedge clk);
    io.in_valid = 1'b0;
    wait_res("t5_wait", 6);
    if (acc_cyc.size() >= 6)
      chk_eq("t5_spacing", acc_cyc[5] - acc_cyc[4], N + 2);
    else
      chk_eq("t5_acc_count", acc_cyc.size(), 6);
    check_res("t5a", 4, 1482910, 1482910, 64);
    check_res("t5b", 5, 1816186, -1048576, 64);

    send(1000000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    nov = ov_cnt;
    rst = 1'b1;
    #1;
    chk_eq("t6_rst_rdy", int'(io.in_ready), 0);
    chk_eq("t6_rst_ov", int'(io.out_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_eq("t6_rel_rdy", int'(io.in_ready), 1);
    chk_eq("t6_rel_cos", int'(io.cos_out), 0);
    repeat (30) @(negedge clk);
    chk_eq("t6_no_ov", ov_cnt, nov);
    chk_eq("t6_idle_rdy", int'(io.in_ready), 1);
    acc_cyc.delete();
    res_cyc.delete();
    res_c.delete();
    res_s.delete();
    send(M6);
    wait_res("t6_wait", 1);
    check_res("t6", 0, 1816186, -1048576, 64);

    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(2 * AMAX, 0)) - AMAX;
      nacc = res_c.size();
      send(a);
      wait_res("rnd_wait", nacc + 1);
      check_res($sformatf("rnd%0d", i), nacc, ref_cos(a), ref_sin(a), 100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
